cardinal_nic: RTL and testbench

//   Network interface controller between the cpu NIC port (nicAddr/nicDataIn/nicDataOut/nicEn/nicWrEn)
//   and one Cardinal ring router node. Holds one-packet input and output channel buffers, exposes them

---
 rtl/cardinal_nic.sv | 132 +++++++++++++
 tb/tb_cardinal_nic.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// rtl/cardinal_nic.sv - CPU-facing network interface between a core and one Cardinal ring router node.
module cardinal_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            nicAddr,
    input  logic [0:DATA_WIDTH-1] nicDataIn,
    output logic [0:DATA_WIDTH-1] nicDataOut,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_t;

    localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    chan_t in_state, in_state_next;
    chan_t out_state, out_state_next;

    logic [0:DATA_WIDTH-1] in_buf;
    logic [0:DATA_WIDTH-1] out_buf;

    logic in_full, out_full;
    logic cpu_read, cpu_write;
    logic eject, drain_in, accept_write, inject;

    assign in_full   = (in_state == FULL);
    assign out_full  = (out_state == FULL);
    assign cpu_read  = nicEn & ~nicWrEn;
    assign cpu_write = nicEn & nicWrEn;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state  <= EMPTY;
            out_state <= EMPTY;
        end else begin
            in_state  <= in_state_next;
            out_state <= out_state_next;
        end
    end

    // Both channel decisions use pre-edge occupancy, so a write that races an
    // injection sees the buffer as still full and is dropped.
    always_comb begin
        in_state_next  = in_state;
        out_state_next = out_state;
        net_ri         = 1'b0;
        eject          = 1'b0;
        drain_in       = 1'b0;
        accept_write   = 1'b0;
        inject         = 1'b0;

        case (in_state)
            EMPTY: begin
                net_ri = 1'b1;
                if (net_si) begin
                    eject         = 1'b1;
                    in_state_next = FULL;
                end
            end
            FULL: begin
                if (cpu_read && nicAddr == ADDR_IN_BUF) begin
                    drain_in      = 1'b1;
                    in_state_next = EMPTY;
                end
            end
            default: in_state_next = EMPTY;
        endcase

        case (out_state)
            EMPTY: begin
                if (cpu_write && nicAddr == ADDR_OUT_BUF) begin
                    accept_write   = 1'b1;
                    out_state_next = FULL;
                end
            end
            FULL: begin
                if (net_ro && (out_buf[VC_BIT] == net_polarity)) begin
                    inject         = 1'b1;
                    out_state_next = EMPTY;
                end
            end
            default: out_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf     <= '0;
            out_buf    <= '0;
            nicDataOut <= '0;
            net_so     <= 1'b0;
            net_do     <= '0;
        end else begin
            if (cpu_read) begin
                case (nicAddr)
                    ADDR_IN_BUF:     nicDataOut <= in_buf;
                    ADDR_IN_STATUS:  nicDataOut <= {{(DATA_WIDTH-1){1'b0}}, in_full};
                    ADDR_OUT_BUF:    nicDataOut <= out_buf;
                    ADDR_OUT_STATUS: nicDataOut <= {{(DATA_WIDTH-1){1'b0}}, out_full};
                    default:         nicDataOut <= nicDataOut;
                endcase
            end
            if (eject) begin
                in_buf <= net_di;
            end
            if (accept_write) begin
                out_buf <= nicDataIn;
            end
            net_so <= inject;
            if (inject) begin
                net_do <= out_buf;
            end
        end
    end

    logic unused_drain;
    assign unused_drain = drain_in;

endmodule

// File: tb/tb_cardinal_nic.sv
// tb/tb_cardinal_nic.sv - scoreboard bench for cardinal_nic against a queue-based reference model.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  nicAddr = 2'b00;
    logic [0:63] nicDataIn = '0;
    logic [0:63] nicDataOut;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [0:63] net_di = '0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [0:63] net_do;
    logic        net_polarity = 1'b0;

    cardinal_nic #(.DATA_WIDTH(64), .VC_BIT(0)) dut (
        .clk(clk), .reset(reset), .nicAddr(nicAddr), .nicDataIn(nicDataIn),
        .nicDataOut(nicDataOut), .nicEn(nicEn), .nicWrEn(nicWrEn),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di), .net_so(net_so),
        .net_ro(net_ro), .net_do(net_do), .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: each channel is a queue holding at most one packet;
    // last_in/last_out remember what the CPU-visible buffer registers contain.
    logic [0:63] in_q[$];
    logic [0:63] out_q[$];
    logic [0:63] last_in = '0;
    logic [0:63] last_out = '0;
    logic [0:63] rd_exp[$];
    logic [0:63] inj_exp[$];

    task automatic chk(input string name, input logic [0:63] act, input logic [0:63] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    task automatic step(input bit en, input bit wr, input logic [1:0] addr, input logic [0:63] din,
                        input bit si, input logic [0:63] di, input bit ro, input bit pol);
        int in_had, out_had;
        logic [0:63] pkt;
        @(negedge clk);
        reset = 1'b0;
        nicEn = en; nicWrEn = wr; nicAddr = addr; nicDataIn = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
        in_had  = in_q.size();
        out_had = out_q.size();
        if (en && !wr) begin
            case (addr)
                2'b00: rd_exp.push_back(last_in);
                2'b01: rd_exp.push_back(64'(in_had));
                2'b10: rd_exp.push_back(last_out);
                default: rd_exp.push_back(64'(out_had));
            endcase
        end
        if (out_had == 1 && ro) begin
            pkt = out_q[0];
            if (pkt[0] == pol) begin
                inj_exp.push_back(pkt);
                void'(out_q.pop_front());
            end
        end
        if (en && wr && addr == 2'b10 && out_had == 0) begin
            out_q.push_back(din);
            last_out = din;
        end
        if (en && !wr && addr == 2'b00 && in_had == 1) void'(in_q.pop_front());
        if (si && in_had == 0) begin
            in_q.push_back(di);
            last_in = di;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, 0, 2'b00, '0, 0, '0, 0, 0);
    endtask

    task automatic rd(input logic [1:0] addr);
        step(1, 0, addr, '0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        nicEn = 1'b0; nicWrEn = 1'b0; net_si = 1'b1; net_ro = 1'b1; net_polarity = 1'b0;
        in_q.delete(); out_q.delete(); rd_exp.delete(); inj_exp.delete();
        last_in = '0; last_out = '0;
        @(posedge clk);
        #2;
        chk("reset_nicDataOut", nicDataOut, '0);
        chk("reset_net_so", 64'(net_so), 64'd0);
        chk("reset_net_do", net_do, '0);
        chk("reset_net_ri", 64'(net_ri), 64'd1);
    endtask

    bit rd_was;
    always @(posedge clk) begin
        rd_was = nicEn && !nicWrEn && !reset;
        #1;
        chk("net_ri", 64'(net_ri), 64'(in_q.size() == 0));
        if (rd_was) begin
            if (rd_exp.size() == 0) chk("read_unexpected", nicDataOut, 'x);
            else chk("read_data", nicDataOut, rd_exp.pop_front());
        end
        if (net_so) begin
            if (inj_exp.size() == 0) chk("net_so_unexpected", 64'd1, 64'd0);
            else chk("net_do", net_do, inj_exp.pop_front());
        end else if (!reset && inj_exp.size() != 0) begin
            chk("net_so_missing", 64'd0, 64'd1);
            void'(inj_exp.pop_front());
        end
    end

    logic [0:63] x_pkt, y_pkt, w_pkt, z_pkt;

    initial begin
        do_reset();
        // Mid-operation reset with both buffers full and an injection enabled.
        step(0, 0, 2'b00, '0, 1, 64'hDEAD_0000_0000_0001, 0, 0);
        step(1, 1, 2'b10, 64'h1111_0000_0000_0000, 0, '0, 0, 0);
        do_reset();
        rd(2'b01);
        rd(2'b11);

        step(0, 0, 2'b00, '0, 1, 64'hA5A5_0000_0000_0001, 0, 0);
        rd(2'b01);
        rd(2'b00);
        rd(2'b01);
        rd(2'b00);

        step(1, 1, 2'b10, 64'h0123_4567_89AB_CDEF, 0, '0, 1, 1);
        step(0, 0, 2'b00, '0, 0, '0, 1, 1);
        step(0, 0, 2'b00, '0, 0, '0, 1, 1);
        step(0, 0, 2'b00, '0, 0, '0, 1, 0);
        step(0, 0, 2'b00, '0, 0, '0, 1, 0);
        rd(2'b11);

        x_pkt = 64'h8000_0000_0000_00AA;
        y_pkt = 64'h0000_0000_0000_00BB;
        step(1, 1, 2'b10, x_pkt, 0, '0, 0, 0);
        step(1, 1, 2'b10, y_pkt, 0, '0, 0, 0);
        rd(2'b10);
        rd(2'b11);
        step(0, 0, 2'b00, '0, 0, '0, 1, 1);

        w_pkt = 64'h7777_0000_0000_0001;
        z_pkt = 64'h3333_0000_0000_0002;
        step(1, 1, 2'b10, w_pkt, 0, '0, 0, 0);
        step(1, 1, 2'b10, z_pkt, 0, '0, 1, 0);
        rd(2'b11);
        rd(2'b10);

        for (int i = 0; i < 24; i++)
            step(1, 0, 2'b00, '0, 1, {$urandom, $urandom}, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                      {$urandom, $urandom}, $urandom_range(0, 1), {$urandom, $urandom},
                      $urandom_range(0, 1), $urandom_range(0, 1));
        end

        idle();
        idle();
        chk("read_queue_drained", 64'(rd_exp.size()), 64'd0);
        chk("inject_queue_drained", 64'(inj_exp.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
